// File: rtl/addsub_result_fifo.sv
// Result FIFO behind the add/sub stage: captures each sum together with its
// {ovf, carry, zero, neg} flags and counts accepted overflows (saturating).
module addsub_result_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic                   in_m,
  input  logic [W-1:0]           in_sum,
  input  logic                   in_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_sum,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W+3:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          ovf;
  logic          zero;
  logic [3:0]    flags;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Subtraction overflows when the operand signs differ; addition when they match.
  always_comb begin
    ovf   = 1'b0;
    zero  = 1'b0;
    flags = 4'b0000;
    if (in_m) begin
      ovf = (in_a[W-1] != in_b[W-1]) && (in_sum[W-1] != in_a[W-1]);
    end else begin
      ovf = (in_a[W-1] == in_b[W-1]) && (in_sum[W-1] != in_a[W-1]);
    end
    zero  = (in_sum == '0);
    flags = {ovf, in_cout, zero, in_sum[W-1]};
  end

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {flags, in_sum};
    end
  end

  assign out_sum   = mem[rd_ptr][W-1:0];
  assign out_flags = mem[rd_ptr][W+3:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 8'd0;
    end else if (push && ovf && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Directed bench for addsub_result_fifo: a negedge monitor scoreboards every
// pop against hand-computed entries queued when the push is seen.
module tb_addsub_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_m;
  logic [3:0] in_sum;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic [3:0] out_flags;
  logic [2:0] count;
  logic [7:0] ovf_cnt;

  logic [3:0] exp_sum;
  logic [3:0] exp_flags;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];

  // Hand-computed vectors: a, b, m, sum, cout and the flags {ovf,carry,zero,neg}
  logic [3:0] va [8] = '{4'b1010, 4'b1000, 4'b1111, 4'b1010, 4'b0011, 4'b0001, 4'b0111, 4'b0101};
  logic [3:0] vb [8] = '{4'b1100, 4'b0100, 4'b1010, 4'b0110, 4'b0011, 4'b0010, 4'b0001, 4'b0111};
  logic       vm [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] vs [8] = '{4'b0110, 4'b1100, 4'b0101, 4'b0100, 4'b0000, 4'b0011, 4'b1000, 4'b1110};
  logic       vc [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] vf [8] = '{4'b1100, 4'b0001, 4'b0100, 4'b1100, 4'b0110, 4'b0000, 4'b1001, 4'b0001};

  addsub_result_fifo #(.W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_m      (in_m),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .count     (count),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: head is checked before any same-cycle push is queued (no bypass).
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL pop_unexpected: got %0h expected none", {out_sum, out_flags});
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if ({out_sum, out_flags} != e) begin
            bad++;
            $display("[TB] FAIL pop_entry: got %0h expected %0h", {out_sum, out_flags}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({exp_sum, exp_flags});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx);
    in_valid  = 1'b1;
    in_a      = va[idx];
    in_b      = vb[idx];
    in_m      = vm[idx];
    in_sum    = vs[idx];
    in_cout   = vc[idx];
    exp_sum   = vs[idx];
    exp_flags = vf[idx];
  endtask

  task automatic pushOne(input int idx);
    applyStimulus(idx);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (!out_valid) done = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checkOutput({name, "_drained"}, int'(done), 1);
    checkOutput({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_m      = 1'b0;
    in_sum    = '0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    exp_sum   = '0;
    exp_flags = '0;
    doReset();

    sample();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_ovf_cnt", ovf_cnt, 0);
    tick();

    // Single push: visible next cycle with overflow flagged
    pushOne(0);
    sample();
    checkOutput("t1_out_valid", out_valid, 1);
    checkOutput("t1_sum", out_sum, 4'b0110);
    checkOutput("t1_flags", out_flags, 4'b1100);
    checkOutput("t1_count", count, 1);
    checkOutput("t1_ovf_cnt", ovf_cnt, 1);
    tick();
    drain("t1");

    // Two pushes back to back, popped in order
    applyStimulus(1);
    tick();
    applyStimulus(2);
    tick();
    in_valid = 1'b0;
    drain("t2");

    // Subtract overflow and zero result
    applyStimulus(3);
    tick();
    applyStimulus(4);
    tick();
    in_valid = 1'b0;
    sample();
    checkOutput("t3_ovf_cnt", ovf_cnt, 2);
    tick();
    drain("t3");

    // Fill, hold off a fifth push, then push+pop across the pointer wrap
    pushOne(5);
    pushOne(6);
    pushOne(7);
    pushOne(0);
    sample();
    checkOutput("t4_count_full", count, 4);
    checkOutput("t4_in_ready_full", in_ready, 0);
    checkOutput("t4_ovf_cnt", ovf_cnt, 4);
    tick();
    applyStimulus(1);
    tick();
    sample();
    checkOutput("t4_held_count", count, 4);
    checkOutput("t4_held_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b1;
    sample();
    checkOutput("t4_pop_in_ready", in_ready, 0);
    tick();
    sample();
    checkOutput("t4_after_pop_count", count, 3);
    checkOutput("t4_after_pop_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain("t4");

    // Steady stream at occupancy 2
    pushOne(2);
    pushOne(3);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((4 + i) % 8);
      sample();
      checkOutput("t5_count", count, 2);
      tick();
    end
    in_valid = 1'b0;
    drain("t5");
    checkOutput("t5_ovf_cnt", ovf_cnt, 8);

    // Overflow counter saturates at 255
    out_ready = 1'b1;
    applyStimulus(0);
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    drain("t6");
    checkOutput("t6_ovf_sat", ovf_cnt, 255);

    // Mid-operation reset discards entries and same-cycle push/pop
    doReset();
    pushOne(0);
    pushOne(3);
    pushOne(5);
    sample();
    checkOutput("t7_pre_count", count, 3);
    checkOutput("t7_pre_ovf_cnt", ovf_cnt, 2);
    tick();
    applyStimulus(6);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    sample();
    checkOutput("t7_count", count, 0);
    checkOutput("t7_out_valid", out_valid, 0);
    checkOutput("t7_in_ready", in_ready, 1);
    checkOutput("t7_ovf_cnt", ovf_cnt, 0);
    tick();
    pushOne(4);
    drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
